// File: rtl/proc_run_controller.sv
// rtl/proc_run_controller.sv - sequences a processor through reset hold, run and termination
//
// Ports:
//   CLK            rising-edge clock
//   RESET          synchronous active-high reset
//   start          run request, honoured in IDLE and DONE only
//   boot_pc        start address, latched on an accepted start
//   halt_req       processor halt request, sampled in RUN
//   abort          external abort, sampled in RUN
//   proc_rst       active-high processor reset
//   proc_start_pc  start PC presented to the processor
//   proc_run       processor step enable
//   busy           high in HOLD and RUN
//   done           high in DONE
//   halted         run ended by halt_req
//   aborted        run ended by abort
//   timeout        run ended by the cycle budget
//   err_align      last start rejected because boot_pc was misaligned
//   cycle_count    cycles proc_run was high in the current or last run (saturating)
module proc_run_controller #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [31:0]      boot_pc,
    input  logic             halt_req,
    input  logic             abort,
    output logic             proc_rst,
    output logic [31:0]      proc_start_pc,
    output logic             proc_run,
    output logic             busy,
    output logic             done,
    output logic             halted,
    output logic             aborted,
    output logic             timeout,
    output logic             err_align,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    // Compared at 64 bits so a budget wider than the counter can never alias
    // onto a truncated count value.
    localparam logic [63:0] MAX_LAST = 64'(MAX_CYCLES) - 64'd1;

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [31:0]       pc_q, pc_d;
    logic              rst_q, rst_d;
    logic              run_q, run_d;
    logic              halted_q, halted_d;
    logic              aborted_q, aborted_d;
    logic              timeout_q, timeout_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  count_inc;
    logic              budget_hit;

    assign count_inc  = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    assign budget_hit = (MAX_CYCLES != 0) && (64'(cycle_count_q) == MAX_LAST);

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        pc_d          = pc_q;
        rst_d         = rst_q;
        run_d         = run_q;
        halted_d      = halted_q;
        aborted_d     = aborted_q;
        timeout_d     = timeout_q;
        err_d         = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    halted_d  = 1'b0;
                    aborted_d = 1'b0;
                    timeout_d = 1'b0;
                    if (boot_pc[1:0] == 2'b00) begin
                        state_d       = S_HOLD;
                        pc_d          = boot_pc;
                        cycle_count_d = '0;
                        hold_cnt_d    = '0;
                        rst_d         = 1'b1;
                        err_d         = 1'b0;
                    end else begin
                        // Rejected start: proc_rst keeps whatever level it had,
                        // so a processor never released stays in reset.
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    rst_d   = 1'b0;
                    run_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                // The exit edge itself is a counted run cycle.
                cycle_count_d = count_inc;
                if (abort) begin
                    state_d   = S_DONE;
                    run_d     = 1'b0;
                    aborted_d = 1'b1;
                end else if (halt_req) begin
                    state_d  = S_DONE;
                    run_d    = 1'b0;
                    halted_d = 1'b1;
                end else if (budget_hit) begin
                    state_d   = S_DONE;
                    run_d     = 1'b0;
                    timeout_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            pc_q          <= '0;
            rst_q         <= 1'b1;
            run_q         <= 1'b0;
            halted_q      <= 1'b0;
            aborted_q     <= 1'b0;
            timeout_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            pc_q          <= pc_d;
            rst_q         <= rst_d;
            run_q         <= run_d;
            halted_q      <= halted_d;
            aborted_q     <= aborted_d;
            timeout_q     <= timeout_d;
            err_q         <= err_d;
        end
    end

    assign proc_rst      = rst_q;
    assign proc_run      = run_q;
    assign proc_start_pc = pc_q;
    assign busy          = (state_q == S_HOLD) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign halted        = halted_q;
    assign aborted       = aborted_q;
    assign timeout       = timeout_q;
    assign err_align     = err_q;
    assign cycle_count   = cycle_count_q;

endmodule
